// File: rtl/elevator_pkg.sv
// Shared state encoding, default timing constants and a constant-evaluable log2 helper.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  localparam int TRAVEL_CYCLES_DEF = 50;
  localparam int DOOR_CYCLES_DEF   = 40;

  // Smallest r with (1 << r) >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/elevator_req_scan.sv
// Combinational request scan: are there effective requests above, below or at a floor.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  localparam int FLOOR_W = (clog2(NUM_FLOORS) > 1) ? clog2(NUM_FLOORS) : 1
) (
  input  logic [NUM_FLOORS-1:0] eff,
  input  logic [FLOOR_W-1:0]    curr_floor,
  output logic                  above,
  output logic                  below,
  output logic                  here
);

  // Classify every requested floor relative to the reference floor.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (eff[i]) begin
        if (i > int'(curr_floor)) begin
          above = 1'b1;
        end else if (i < int'(curr_floor)) begin
          below = 1'b1;
        end else begin
          here = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN elevator controller: latches requests, sweeps in one direction
// while work remains ahead, then reverses. Moore motor/door outputs.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
  parameter int DOOR_CYCLES   = DOOR_CYCLES_DEF,
  localparam int FLOOR_W = (clog2(NUM_FLOORS) > 1) ? clog2(NUM_FLOORS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    curr_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  arrived
);

  localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TIMER_W    = clog2(MAX_CYCLES + 1);
  localparam logic [NUM_FLOORS-1:0] FLOOR0_MASK = NUM_FLOORS'(1);
  localparam logic [TIMER_W-1:0]    TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0]    DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [TIMER_W-1:0]      timer, timer_nxt;
  logic [FLOOR_W-1:0]      floor_nxt;
  logic [FLOOR_W-1:0]      arrive_floor;
  logic [NUM_FLOORS-1:0]   pending_nxt;
  logic [NUM_FLOORS-1:0]   eff;
  logic [NUM_FLOORS-1:0]   curr_mask;
  logic [NUM_FLOORS-1:0]   arrive_mask;
  logic                    dir_up_nxt;
  logic                    arrived_nxt;
  logic                    above, below, here;
  logic                    arr_above, arr_below, arr_here;

  assign eff          = pending | req;
  // The floor the car reaches at the end of the current travel leg.
  assign arrive_floor = (state == MOVE_DOWN) ? curr_floor - FLOOR_W'(1)
                                             : curr_floor + FLOOR_W'(1);
  assign curr_mask    = FLOOR0_MASK << curr_floor;
  assign arrive_mask  = FLOOR0_MASK << arrive_floor;

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_curr (
    .eff        (eff),
    .curr_floor (curr_floor),
    .above      (above),
    .below      (below),
    .here       (here)
  );

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan_arrive (
    .eff        (eff),
    .curr_floor (arrive_floor),
    .above      (arr_above),
    .below      (arr_below),
    .here       (arr_here)
  );

  // Next-state, timer, floor, direction and pending-latch decisions.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    floor_nxt   = curr_floor;
    dir_up_nxt  = dir_up;
    arrived_nxt = 1'b0;
    pending_nxt = pending | req;
    case (state)
      IDLE: begin
        // The current floor is served directly, never latched.
        pending_nxt = (pending | req) & ~curr_mask;
        timer_nxt   = '0;
        if (here) begin
          state_nxt = DOOR_OPEN;
        end else if (above && (dir_up || !below)) begin
          state_nxt  = MOVE_UP;
          dir_up_nxt = 1'b1;
        end else if (below) begin
          state_nxt  = MOVE_DOWN;
          dir_up_nxt = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (timer == TRAVEL_LAST) begin
          timer_nxt   = '0;
          floor_nxt   = arrive_floor;
          arrived_nxt = 1'b1;
          if (arr_here) begin
            // Service clears the bit even if it is requested in the same cycle.
            state_nxt   = DOOR_OPEN;
            pending_nxt = (pending | req) & ~arrive_mask;
          end else if ((state == MOVE_UP) ? arr_above : arr_below) begin
            state_nxt = state;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      DOOR_OPEN: begin
        pending_nxt = (pending | req) & ~curr_mask;
        if ((req & curr_mask) != '0) begin
          // A same-floor call keeps the door open a full dwell from now.
          timer_nxt = '0;
        end else if (timer == DOOR_LAST) begin
          timer_nxt = '0;
          if (dir_up && above) begin
            state_nxt = MOVE_UP;
          end else if (below) begin
            state_nxt  = MOVE_DOWN;
            dir_up_nxt = 1'b0;
          end else if (above) begin
            state_nxt  = MOVE_UP;
            dir_up_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          timer_nxt = timer + TIMER_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and control registers; reset wins over any travel or door activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      curr_floor <= '0;
      pending    <= '0;
      dir_up     <= 1'b1;
      arrived    <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      curr_floor <= floor_nxt;
      pending    <= pending_nxt;
      dir_up     <= dir_up_nxt;
      arrived    <= arrived_nxt;
    end
  end

  assign motor_up   = (state == MOVE_UP);
  assign motor_down = (state == MOVE_DOWN);
  assign door_open  = (state == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl: default 4-floor instance plus an
// 8-floor fast instance for the randomized sweep.
module tb_elevator_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       motor_up, motor_down, door_open, dir_up, arrived;
  logic [1:0] curr_floor;
  logic [3:0] pending;

  logic       s_reset;
  logic [7:0] s_req;
  logic       s_motor_up, s_motor_down, s_door_open, s_dir_up, s_arrived;
  logic [2:0] s_curr_floor;
  logic [7:0] s_pending;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic prev_door = 1'b0;

  elevator_scan_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .motor_up   (motor_up),
    .motor_down (motor_down),
    .door_open  (door_open),
    .curr_floor (curr_floor),
    .pending    (pending),
    .dir_up     (dir_up),
    .arrived    (arrived)
  );

  elevator_scan_ctrl #(.NUM_FLOORS(8), .TRAVEL_CYCLES(3), .DOOR_CYCLES(2)) s_dut (
    .clk        (clk),
    .reset      (s_reset),
    .req        (s_req),
    .motor_up   (s_motor_up),
    .motor_down (s_motor_down),
    .door_open  (s_door_open),
    .curr_floor (s_curr_floor),
    .pending    (s_pending),
    .dir_up     (s_dir_up),
    .arrived    (s_arrived)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every door opening must match the next expected stop floor.
  always @(negedge clk) begin
    if (door_open && !prev_door) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stop_order: door opened at floor %0d, no stop expected", curr_floor);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(curr_floor) != e) begin
          errors++;
          $display("FAIL stop_order: door opened at floor %0d, expected floor %0d", curr_floor, e);
        end
      end
    end
    prev_door = door_open;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    checks++;
    if ({motor_up, motor_down, door_open, arrived} !== 4'b0000 || curr_floor !== 2'd0 ||
        pending !== 4'b0000 || dir_up !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: up=%0b dn=%0b door=%0b arr=%0b floor=%0d pend=%b dir=%0b, expected 0 0 0 0 0 0000 1",
               motor_up, motor_down, door_open, arrived, curr_floor, pending, dir_up);
    end
    reset = 1'b0;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    checks++;
    if (motor_up !== 1'b1 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL reset_start_move: up=%0b pend=%b, expected 1 1000", motor_up, pending);
    end
    repeat (69) tick();
    checks++;
    if (motor_up !== 1'b1 || curr_floor !== 2'd1) begin
      errors++;
      $display("FAIL reset_mid_travel_pre: up=%0b floor=%0d, expected 1 1", motor_up, curr_floor);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (motor_up !== 1'b0 || pending !== 4'b0000 || curr_floor !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_travel: up=%0b pend=%b floor=%0d, expected 0 0000 0", motor_up, pending, curr_floor);
    end
  endtask

  task automatic test_single_request();
    int cnt;
    exp_q.push_back(1);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    cnt = 0;
    while (motor_up && cnt < 200) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 50) begin
      errors++;
      $display("FAIL single_travel_len: motor_up cycles %0d, expected 50", cnt);
    end
    checks++;
    if (curr_floor !== 2'd1 || arrived !== 1'b1 || door_open !== 1'b1) begin
      errors++;
      $display("FAIL single_arrive: floor=%0d arr=%0b door=%0b, expected 1 1 1", curr_floor, arrived, door_open);
    end
    cnt = 0;
    while (door_open && cnt < 200) begin
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 40) begin
      errors++;
      $display("FAIL single_door_len: door cycles %0d, expected 40", cnt);
    end
    checks++;
    if ({motor_up, motor_down, door_open, arrived} !== 4'b0000 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: up=%0b dn=%0b door=%0b arr=%0b pend=%b, expected all 0",
               motor_up, motor_down, door_open, arrived, pending);
    end
  endtask

  task automatic test_door_hold();
    int cnt;
    do_reset();
    exp_q.push_back(0);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    checks++;
    if (door_open !== 1'b1 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL hold_open_latency: door=%0b pend=%b, expected 1 0000", door_open, pending);
    end
    cnt = 0;
    while (door_open && cnt < 300) begin
      cnt++;
      req = (cnt == 30) ? 4'b0001 : 4'b0000;
      tick();
      if (cnt == 30) begin
        checks++;
        if (pending !== 4'b0000 || door_open !== 1'b1) begin
          errors++;
          $display("FAIL hold_repulse: pend=%b door=%0b, expected 0000 1", pending, door_open);
        end
      end
    end
    req = 4'b0000;
    checks++;
    if (cnt != 70) begin
      errors++;
      $display("FAIL hold_door_len: door cycles %0d, expected 70", cnt);
    end
  endtask

  task automatic test_scan_pickup();
    int n;
    do_reset();
    exp_q.push_back(2);
    exp_q.push_back(3);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    repeat (59) tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    checks++;
    if (pending !== 4'b1100 || curr_floor !== 2'd1 || motor_up !== 1'b1) begin
      errors++;
      $display("FAIL scan_latch: pend=%b floor=%0d up=%0b, expected 1100 1 1", pending, curr_floor, motor_up);
    end
    n = 0;
    while (!door_open && n < 300) begin tick(); n++; end
    checks++;
    if (door_open !== 1'b1 || curr_floor !== 2'd2) begin
      errors++;
      $display("FAIL scan_stop2: door=%0b floor=%0d, expected 1 2", door_open, curr_floor);
    end
    n = 0;
    while (door_open && n < 300) begin tick(); n++; end
    checks++;
    if (n != 40 || motor_up !== 1'b1) begin
      errors++;
      $display("FAIL scan_continue: door cycles %0d up=%0b, expected 40 1", n, motor_up);
    end
    n = 0;
    while (!door_open && n < 300) begin tick(); n++; end
    n = 0;
    while (door_open && n < 300) begin tick(); n++; end
    checks++;
    if (curr_floor !== 2'd3 || pending !== 4'b0000 || {motor_up, motor_down, door_open} !== 3'b000) begin
      errors++;
      $display("FAIL scan_end: floor=%0d pend=%b outs=%b, expected 3 0000 000",
               curr_floor, pending, {motor_up, motor_down, door_open});
    end
  endtask

  task automatic test_direction();
    int n;
    do_reset();
    exp_q.push_back(3);
    exp_q.push_back(0);
    req = 4'b1000;
    tick();
    req = 4'b0000;
    repeat (59) tick();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    checks++;
    if (motor_up !== 1'b1 || pending !== 4'b1001) begin
      errors++;
      $display("FAIL dir_keep_up: up=%0b pend=%b, expected 1 1001", motor_up, pending);
    end
    n = 0;
    while (!door_open && n < 300) begin tick(); n++; end
    n = 0;
    while (door_open && n < 300) begin tick(); n++; end
    checks++;
    if (motor_down !== 1'b1 || dir_up !== 1'b0 || curr_floor !== 2'd3) begin
      errors++;
      $display("FAIL dir_reverse: dn=%0b dir=%0b floor=%0d, expected 1 0 3", motor_down, dir_up, curr_floor);
    end
    n = 0;
    while (!door_open && n < 400) begin tick(); n++; end
    n = 0;
    while (door_open && n < 300) begin tick(); n++; end
    checks++;
    if (curr_floor !== 2'd0 || pending !== 4'b0000 || {motor_up, motor_down, door_open} !== 3'b000) begin
      errors++;
      $display("FAIL dir_end: floor=%0d pend=%b outs=%b, expected 0 0000 000",
               curr_floor, pending, {motor_up, motor_down, door_open});
    end
    // Tie: idle at floor 1 heading up, requests both above and below.
    do_reset();
    exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(0);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    n = 0;
    while (!door_open && n < 300) begin tick(); n++; end
    n = 0;
    while (door_open && n < 300) begin tick(); n++; end
    req = 4'b1001;
    tick();
    req = 4'b0000;
    checks++;
    if (motor_up !== 1'b1 || motor_down !== 1'b0 || dir_up !== 1'b1) begin
      errors++;
      $display("FAIL tie_up_first: up=%0b dn=%0b dir=%0b, expected 1 0 1", motor_up, motor_down, dir_up);
    end
    n = 0;
    while (!(door_open && curr_floor == 2'd0) && n < 800) begin tick(); n++; end
    n = 0;
    while (door_open && n < 300) begin tick(); n++; end
    checks++;
    if (exp_q.size() != 0 || pending !== 4'b0000 || curr_floor !== 2'd0) begin
      errors++;
      $display("FAIL tie_end: stops left %0d pend=%b floor=%0d, expected 0 0000 0",
               exp_q.size(), pending, curr_floor);
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0] outstanding;
    int age [8];
    int max_age;
    int overlap_cnt;
    int jump_cnt;
    int prev_floor;
    int fl;
    outstanding = '0;
    max_age = 0;
    overlap_cnt = 0;
    jump_cnt = 0;
    for (int i = 0; i < 8; i++) age[i] = 0;
    s_reset = 1'b1;
    s_req = '0;
    tick();
    tick();
    s_reset = 1'b0;
    prev_floor = int'(s_curr_floor);
    for (int c = 0; c < 5500; c++) begin
      s_req = '0;
      if (c < 5000 && $urandom_range(7) == 0) begin
        fl = $urandom_range(7);
        s_req = 8'd1 << fl;
      end
      outstanding = outstanding | s_req;
      tick();
      if (s_door_open) outstanding[s_curr_floor] = 1'b0;
      if ((int'(s_motor_up) + int'(s_motor_down) + int'(s_door_open)) > 1) overlap_cnt++;
      if (int'(s_curr_floor) != prev_floor &&
          !(s_arrived && (int'(s_curr_floor) == prev_floor + 1 || int'(s_curr_floor) == prev_floor - 1)))
        jump_cnt++;
      prev_floor = int'(s_curr_floor);
      for (int i = 0; i < 8; i++) begin
        if (outstanding[i]) begin
          age[i]++;
          if (age[i] > max_age) max_age = age[i];
        end else begin
          age[i] = 0;
        end
      end
    end
    s_req = '0;
    checks++;
    if (overlap_cnt != 0) begin
      errors++;
      $display("FAIL sweep_exclusive: %0d overlapping cycles, expected 0", overlap_cnt);
    end
    checks++;
    if (jump_cnt != 0) begin
      errors++;
      $display("FAIL sweep_floor_step: %0d illegal floor changes, expected 0", jump_cnt);
    end
    checks++;
    if (max_age > 200) begin
      errors++;
      $display("FAIL sweep_latency: max wait %0d cycles, expected <= 200", max_age);
    end
    checks++;
    if (outstanding !== 8'h00 || s_pending !== 8'h00) begin
      errors++;
      $display("FAIL sweep_drain: outstanding=%b pend=%b, expected 0 0", outstanding, s_pending);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    s_reset = 1'b1;
    s_req = '0;
    test_reset();
    test_single_request();
    test_door_hold();
    test_scan_pickup();
    test_direction();
    test_param_sweep();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stops_outstanding: %0d expected stops never served", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
Parametrised N-floor elevator controller. It replaces the 4-floor, single-request controller in elevator_top.
- Latches multiple outstanding floor requests.
- Serves them in SCAN order: keeps the current direction while requests remain ahead, then reverses.
- Travel and door-dwell times are parameters.
- Door re-opens (timer restarts) on a same-floor call.
- Sits under elevator_top, between the request-button logic and the motor/door drivers.

Parameters:
NUM_FLOORS, 4, number of floors (>=2); floors are indexed 0..NUM_FLOORS-1.
TRAVEL_CYCLES, 50, clock cycles to move one floor (>=1).
DOOR_CYCLES, 40, clock cycles the door stays open (>=1).
FLOOR_W, derived localparam: max(1, clog2(NUM_FLOORS)). Not overridable.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
req  in  NUM_FLOORS  request vector; bit i high for any number of cycles requests floor i.
motor_up  out  1  high while in MOVE_UP.
motor_down  out  1  high while in MOVE_DOWN.
door_open  out  1  high while in DOOR_OPEN.
curr_floor  out  FLOOR_W  current floor index.
pending  out  NUM_FLOORS  latched, unserved requests.
dir_up  out  1  travel direction memory (1 = up).
arrived  out  1  one-cycle pulse on every floor-boundary crossing.

Behaviour:
- Reset: state IDLE; curr_floor=0, pending=0, dir_up=1, arrived=0, timer=0; all motor and door outputs 0. Reset mid-travel or mid-door wins unconditionally at the next edge.
- Outputs are Moore, decoded from the state register. motor_up, motor_down and door_open are mutually exclusive at all times.
- Effective request: eff = pending | req.
- above = OR of eff bits with index > curr_floor; below = OR of eff bits with index < curr_floor.
- Latching: pending <= pending | req each cycle. Exception: bit curr_floor is never set while in IDLE or DOOR_OPEN, because it is served instead.
- IDLE, evaluated on eff, in priority order:
  - eff[curr_floor] -> DOOR_OPEN, timer loaded.
  - else above && (dir_up || !below) -> MOVE_UP, dir_up=1.
  - else below -> MOVE_DOWN, dir_up=0.
  - else stay IDLE.
  - Tie (above and below both set) follows dir_up.
  - Latency: a request sampled at edge k gives motor/door high in cycle k+1.
- MOVE_UP / MOVE_DOWN:
  - Timer counts 0..TRAVEL_CYCLES-1.
  - On the terminal count: curr_floor +1 (up) or -1 (down), arrived=1 for one cycle, timer cleared.
  - The next state is decided at the same edge, using the arriving floor f:
    - pending[f] or req[f] -> DOOR_OPEN; pending[f] cleared (the clear beats a simultaneous set).
    - else requests still ahead in the travel direction -> stay in the same MOVE state.
    - else -> IDLE.
  - curr_floor never leaves 0..NUM_FLOORS-1. A MOVE state is only entered with a request ahead, and pending bits are only cleared by service.
- DOOR_OPEN:
  - Timer counts 0..DOOR_CYCLES-1.
  - req[curr_floor] during the door phase restarts the timer to 0, so the door stays open DOOR_CYCLES cycles after the last press.
  - On expiry (next state):
    - dir_up && above -> MOVE_UP.
    - else below -> MOVE_DOWN, dir_up=0.
    - else above -> MOVE_UP, dir_up=1.
    - else -> IDLE.
- Requests for floors other than curr_floor latch in every state and are never lost.
- Timer width = clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1). No wrap is possible, because the timer clears at terminal count.

Decomposition:
- elevator_pkg:
  - state encoding localparams: IDLE=2'd0, MOVE_UP=2'd1, MOVE_DOWN=2'd2, DOOR_OPEN=2'd3.
  - default TRAVEL_CYCLES and DOOR_CYCLES constants.
  - clog2 helper function.
- Sub-module elevator_req_scan: combinational. Inputs eff and curr_floor (NUM_FLOORS parameter); outputs above, below and here. Verified standalone with exhaustive search for NUM_FLOORS <= 8.
- FSM, timer and pending register stay in elevator_scan_ctrl.

Test Plan:
(Defaults NUM_FLOORS=4, TRAVEL_CYCLES=50, DOOR_CYCLES=40; 10 ns clock.)
1. Reset and reset-mid-travel:
   - Reset held for 2 cycles -> all outputs 0, curr_floor=0.
   - req=4'b1000, then reset asserted 70 cycles later -> next edge: motor_up=0, pending=0, curr_floor=0.
2. Single request:
   - req=4'b0010 pulsed at edge k -> motor_up=1 in cycles k+1..k+50.
   - curr_floor=1 and arrived=1 at k+50.
   - door_open=1 for 40 cycles, then IDLE with all outputs 0.
3. Same-floor call and door hold:
   - IDLE at floor 0, req[0] -> door_open the next cycle.
   - req[0] re-pulsed 30 cycles into the door phase -> door_open lasts 70 cycles in total; pending stays 0.
4. SCAN pickup:
   - From floor 0, req[3] issued; req[2] issued 60 cycles later (after floor 1 is reached).
   - Car stops at 2 with door_open for 40 cycles, then continues to 3; pending ends at 0.
5. Direction memory and reversal:
   - req[0] arrives while the car is moving up 1->3 -> floor 3 is served first, then MOVE_DOWN to 0.
   - Tie case: IDLE at floor 1 with dir_up=1, req=4'b1001 in the same cycle -> MOVE_UP first.
6. Parameter sweep:
   - NUM_FLOORS=8, TRAVEL_CYCLES=3, DOOR_CYCLES=2, random req stream for 5000 cycles.
   - Check: motor/door outputs never overlap; curr_floor stays in 0..7; every request is served within a bounded number of cycles.
